draw_line_stream: RTL and testbench

DRAW_LINE_STREAM -- requirements
Module: draw_line_stream

---
 rtl/draw_line_stream.sv | 137 +++++++++++++
 tb/tb_draw_line_stream.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_line_stream.sv
// Bresenham line walker that streams dash-masked, screen-clipped pixels over a
// valid/ready interface, one candidate point per cycle unless the consumer stalls.
module draw_line_stream #(
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int PAT_W    = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [PAT_W-1:0]   pattern,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               busy,
  output logic               done,
  output logic [COORD_W+1:0] pix_count,
  output logic [1:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds its payload stable until then and never waits on ready.

  localparam int EW = COORD_W + 2;
  localparam int KW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(PAT_W - 1);
  localparam logic [31:0] SW = SCREEN_W;
  localparam logic [31:0] SH = SCREEN_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [COORD_W-1:0]    x, y, x1_q, y1_q, dx, dy;
  logic                  sx_neg, sy_neg;
  logic signed [EW-1:0]  err, err_next;
  logic [KW-1:0]         k;
  logic [PAT_W-1:0]      pat_q;
  logic [COORD_W+1:0]    cnt;

  logic [COORD_W-1:0]    dx_in, dy_in;
  logic signed [EW:0]    e2, dx_w, dy_w;
  logic                  step_x, step_y, emit, advance, at_end;

  assign dx_in = (x1 >= x0) ? x1 - x0 : x0 - x1;
  assign dy_in = (y1 >= y0) ? y1 - y0 : y0 - y1;

  // e2 is one bit wider than err so doubling can never overflow.
  assign e2     = {err, 1'b0};
  assign dx_w   = {3'b000, dx};
  assign dy_w   = {3'b000, dy};
  assign step_x = (e2 >= -dy_w);
  assign step_y = (e2 <= dx_w);

  always_comb begin
    err_next = err;
    if (step_x) err_next = err_next - $signed({2'b00, dy});
    if (step_y) err_next = err_next + $signed({2'b00, dx});
  end

  assign emit    = (32'(x) < SW) && (32'(y) < SH) && pat_q[k];
  assign advance = (state == STEP) && (!emit || pix_ready);
  assign at_end  = (x == x1_q) && (y == y1_q);

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == STEP) || (state == DONE);
  assign done      = (state == DONE);
  assign pix_valid = (state == STEP) && emit;
  assign pix_x     = x;
  assign pix_y     = y;
  assign pix_count = cnt;
  assign dbg_state = state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      dx     <= '0;
      dy     <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      err    <= '0;
      k      <= '0;
      pat_q  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x      <= x0;
            y      <= y0;
            x1_q   <= x1;
            y1_q   <= y1;
            dx     <= dx_in;
            dy     <= dy_in;
            sx_neg <= (x1 < x0);
            sy_neg <= (y1 < y0);
            err    <= $signed({2'b00, dx_in}) - $signed({2'b00, dy_in});
            k      <= '0;
            pat_q  <= pattern;
            cnt    <= '0;
            state  <= STEP;
          end
        end
        STEP: begin
          if (advance) begin
            if (emit) cnt <= cnt + 1'b1;
            if (at_end) begin
              state <= DONE;
            end else begin
              err <= err_next;
              if (step_x) x <= sx_neg ? x - 1'b1 : x + 1'b1;
              if (step_y) y <= sy_neg ? y - 1'b1 : y + 1'b1;
              k <= (k == K_LAST) ? '0 : k + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_line_stream.sv
// Directed bench for draw_line_stream: each scenario task drives a line command
// and compares the captured pixel stream and status against hand-derived values.
module tb_draw_line_stream;

  localparam int CW = 10;
  localparam int PW = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [PW-1:0] pattern = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [CW-1:0] pix_x, pix_y;
  logic          busy, done;
  logic [CW+1:0] pix_count;
  logic [1:0]    dbg_state;

  int tests = 0;
  int fails = 0;
  int step_cnt = 0;
  int done_cnt = 0;
  logic [2*CW-1:0] exp_q[$];
  logic [2*CW-1:0] got_q[$];

  draw_line_stream #(.COORD_W(CW), .SCREEN_W(640), .SCREEN_H(480), .PAT_W(PW)) dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .pattern(pattern),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .done(done), .pix_count(pix_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Capture accepted pixels, STEP cycles and done pulses mid-cycle.
  always @(negedge Clk) begin
    if (pix_valid && pix_ready) got_q.push_back({pix_x, pix_y});
    if (busy && !done) step_cnt++;
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [2*CW-1:0] pt(input int a, input int b);
    logic [CW-1:0] ax, by;
    ax = a[CW-1:0];
    by = b[CW-1:0];
    return {ax, by};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear();
    got_q.delete();
    exp_q.delete();
    step_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic start_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic [PW-1:0] pat);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL cmd_ready_wait: got cmd_ready=%0b want 1 within 50 cycles", cmd_ready);
    end
    x0 = ax0[CW-1:0];
    y0 = ay0[CW-1:0];
    x1 = ax1[CW-1:0];
    y1 = ay1[CW-1:0];
    pattern = pat;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge Clk);
      if (done) break;
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL done_wait: got done=%0b want 1 within 300 cycles", done);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b1;
    cmd_valid = 1'b1;
    x0 = 10'd4; y0 = 10'd4; x1 = 10'd8; y1 = 10'd8;
    pattern = '1;
    tick();
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_pix_valid: got %0b want 0", pix_valid); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b want 0", done); end
    tests++; if (pix_count !== '0) begin fails++; $display("FAIL reset_pix_count: got %0d want 0", pix_count); end
    tests++; if (pix_x !== '0 || pix_y !== '0) begin fails++; $display("FAIL reset_pix_xy: got (%0d,%0d) want (0,0)", pix_x, pix_y); end
    tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    cmd_valid = 1'b0;
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_horizontal();
    clear();
    pix_ready = 1'b1;
    exp_q = '{pt(0,0), pt(1,0), pt(2,0), pt(3,0)};
    start_cmd(0, 0, 3, 0, '1);
    wait_done();
    tick();
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL horiz_npix: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL horiz_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_q[i][2*CW-1:CW], got_q[i][CW-1:0], exp_q[i][2*CW-1:CW], exp_q[i][CW-1:0]); end
    end
    tests++; if (step_cnt != 4) begin fails++; $display("FAIL horiz_step_cycles: got %0d want 4", step_cnt); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL horiz_done_pulses: got %0d want 1", done_cnt); end
    tests++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL horiz_after_done: got done=%0b ready=%0b want 0,1", done, cmd_ready); end
    tick();
    tick();
    tests++; if (pix_count !== 12'd4) begin fails++; $display("FAIL horiz_pix_count_hold: got %0d want 4", pix_count); end
  endtask

  task automatic test_steep_reverse();
    clear();
    pix_ready = 1'b1;
    exp_q = '{pt(5,9), pt(5,8), pt(4,7), pt(4,6), pt(4,5), pt(4,4), pt(3,3), pt(3,2)};
    start_cmd(5, 9, 3, 2, '1);
    // A second command offered while busy must not be taken.
    x0 = 10'd100; y0 = 10'd100; x1 = 10'd101; y1 = 10'd100;
    cmd_valid = 1'b1;
    wait_done();
    cmd_valid = 1'b0;
    tick();
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL steep_npix: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL steep_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_q[i][2*CW-1:CW], got_q[i][CW-1:0], exp_q[i][2*CW-1:CW], exp_q[i][CW-1:0]); end
    end
    tests++; if (step_cnt != 8) begin fails++; $display("FAIL steep_step_cycles: got %0d want 8", step_cnt); end
    tests++; if (pix_count !== 12'd8) begin fails++; $display("FAIL steep_pix_count: got %0d want 8", pix_count); end
    tick();
    tests++; if (busy !== 1'b0 || pix_valid !== 1'b0) begin fails++; $display("FAIL steep_ignored_cmd: got busy=%0b pix_valid=%0b want 0,0", busy, pix_valid); end
  endtask

  task automatic test_backpressure();
    clear();
    pix_ready = 1'b1;
    exp_q = '{pt(0,0), pt(1,1), pt(2,2)};
    start_cmd(0, 0, 2, 2, '1);
    tick();
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (pix_valid !== 1'b1 || pix_x !== 10'd1 || pix_y !== 10'd1) begin fails++; $display("FAIL bp_hold[%0d]: got valid=%0b (%0d,%0d) want 1 (1,1)", i, pix_valid, pix_x, pix_y); end
    end
    pix_ready = 1'b1;
    wait_done();
    tick();
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_npix: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_q[i][2*CW-1:CW], got_q[i][CW-1:0], exp_q[i][2*CW-1:CW], exp_q[i][CW-1:0]); end
    end
    tests++; if (step_cnt != 6) begin fails++; $display("FAIL bp_step_cycles: got %0d want 6", step_cnt); end
    tests++; if (pix_count !== 12'd3) begin fails++; $display("FAIL bp_pix_count: got %0d want 3", pix_count); end
  endtask

  task automatic test_clip_and_point();
    clear();
    pix_ready = 1'b1;
    exp_q = '{pt(638,5), pt(639,5)};
    start_cmd(638, 5, 642, 5, '1);
    wait_done();
    tick();
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL clip_npix: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL clip_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_q[i][2*CW-1:CW], got_q[i][CW-1:0], exp_q[i][2*CW-1:CW], exp_q[i][CW-1:0]); end
    end
    tests++; if (step_cnt != 5) begin fails++; $display("FAIL clip_step_cycles: got %0d want 5", step_cnt); end
    tests++; if (pix_count !== 12'd2) begin fails++; $display("FAIL clip_pix_count: got %0d want 2", pix_count); end

    clear();
    exp_q = '{pt(7,7)};
    start_cmd(7, 7, 7, 7, '1);
    wait_done();
    tick();
    tests++; if (got_q.size() != 1) begin fails++; $display("FAIL point_npix: got %0d want 1", got_q.size()); end
    else begin
      tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL point_pix: got (%0d,%0d) want (7,7)", got_q[0][2*CW-1:CW], got_q[0][CW-1:0]); end
    end
    tests++; if (step_cnt != 1) begin fails++; $display("FAIL point_step_cycles: got %0d want 1", step_cnt); end
    tests++; if (pix_count !== 12'd1) begin fails++; $display("FAIL point_pix_count: got %0d want 1", pix_count); end
  endtask

  task automatic test_dash();
    clear();
    pix_ready = 1'b1;
    exp_q = '{pt(0,0), pt(2,0), pt(4,0), pt(6,0)};
    start_cmd(0, 0, 7, 0, 4'b0101);
    wait_done();
    tick();
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL dash_npix: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL dash_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_q[i][2*CW-1:CW], got_q[i][CW-1:0], exp_q[i][2*CW-1:CW], exp_q[i][CW-1:0]); end
    end
    tests++; if (step_cnt != 8) begin fails++; $display("FAIL dash_step_cycles: got %0d want 8", step_cnt); end
    tests++; if (pix_count !== 12'd4) begin fails++; $display("FAIL dash_pix_count: got %0d want 4", pix_count); end
  endtask

  task automatic test_reset_mid();
    clear();
    pix_ready = 1'b1;
    start_cmd(0, 0, 9, 0, '1);
    tick();
    tick();
    tick();
    Reset = 1'b1;
    pix_ready = 1'b0;
    tick();
    tests++; if (pix_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid_abort: got valid=%0b busy=%0b want 0,0", pix_valid, busy); end
    tests++; if (pix_count !== '0) begin fails++; $display("FAIL rst_mid_pix_count: got %0d want 0", pix_count); end
    Reset = 1'b0;
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tests++; if (done_cnt != 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt); end
    tests++; if (got_q.size() != 3) begin fails++; $display("FAIL rst_mid_npix: got %0d want 3", got_q.size()); end

    clear();
    exp_q = '{pt(2,1), pt(3,1), pt(4,1)};
    start_cmd(2, 1, 4, 1, '1);
    wait_done();
    tick();
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rst_next_npix: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rst_next_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_q[i][2*CW-1:CW], got_q[i][CW-1:0], exp_q[i][2*CW-1:CW], exp_q[i][CW-1:0]); end
    end
    tests++; if (pix_count !== 12'd3) begin fails++; $display("FAIL rst_next_pix_count: got %0d want 3", pix_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_horizontal();
    test_steep_reverse();
    test_backpressure();
    test_clip_and_point();
    test_dash();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
